alu_arbiter: RTL

- Shares the single ALU instance between NUM_REQ requesters, e.g. the execute stage, branch compare and address generation.
- Round-robin arbitration with a valid/ready request handshake.
- Operands are registered before the ALU and the result is registered after it, cutting the ALU's combinational path out of the requester timing paths.
- Sits between the requesting units and the ALU; the ALU itself is untouched.

---
 rtl/alu_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter that shares one ALU between NUM_REQ requesters.
//   Operands are registered before the ALU and the result is registered after
//   it, so the ALU's combinational path never reaches a requester.
//   Sequence per operation: IDLE (grant) -> EXEC (ALU busy) -> RESP (hold
//   result until the consumer takes it) -> IDLE.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid      : per-requester request valid
//   req_ready      : per-requester accept (one-hot or zero)
//   req_a/req_b    : per-requester operands (32 bit each)
//   req_mode       : per-requester operation and signedness
//   resp_valid     : result available
//   resp_ready     : consumer accepts the result
//   resp_id        : requester that owns the result
//   resp_data      : registered ALU result
//   alu_a/alu_b    : operand registers, to the ALU
//   alu_mode       : ALU mode, ALU_NULL outside EXEC
//   alu_out        : ALU result
//
// Optional feature (macro ALU_ARB_STATS_EN)
//   stats_clr      : synchronous clear of all grant counters
//   grant_count    : per-requester saturating 16-bit grant counters
// -----------------------------------------------------------------------------

package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_NULL = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } alu_sign_t;

    typedef struct packed {
        alu_op_t   operation;
        alu_sign_t signedness;
    } alu_mode_t;

    localparam alu_mode_t ALU_MODE_IDLE = '{operation: ALU_NULL, signedness: UNSIGNED};

endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_a,
    input  logic [NUM_REQ-1:0][31:0]  req_b,
    input  alu_mode_t [NUM_REQ-1:0]   req_mode,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [31:0]               resp_data,
    output logic [31:0]               alu_a,
    output logic [31:0]               alu_b,
    output alu_mode_t                 alu_mode,
    input  logic [31:0]               alu_out
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [NUM_REQ-1:0][15:0]  grant_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    int              cand;

    logic [31:0]     op_a_q, op_b_q;
    alu_mode_t       mode_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     resp_data_q;
    logic [ID_W-1:0] resp_id_q;

    // Circular search starting one past the last winner; the modulo keeps
    // candidates below NUM_REQ, so unused indices are never granted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(rr_ptr_q) + off) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        alu_mode  = ALU_MODE_IDLE;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    accept               = 1'b1;
                    // Gated by rst_n so no grant is visible while reset is held.
                    req_ready[grant_idx] = rst_n;
                    state_d              = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_mode = mode_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            mode_q      <= ALU_MODE_IDLE;
            id_q        <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            if (accept) begin
                op_a_q   <= req_a[grant_idx];
                op_b_q   <= req_b[grant_idx];
                mode_q   <= req_mode[grant_idx];
                id_q     <= grant_idx;
                rr_ptr_q <= grant_idx;
            end
            if (state_q == S_EXEC) begin
                resp_data_q <= alu_out;
                resp_id_q   <= id_q;
            end
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stats_clr) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q[grant_idx] != 16'hFFFF)) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule
